// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - AES-128 key schedule, one round key per handshake; KEYEXP_ZEROIZE_EN clears the key on completion
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    logic [7:0] inv;

    assign inv      = gf_inv(in_byte);
    assign out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, CALC, VALID} state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon;

    assign w0    = key_q[127:96];
    assign w1    = key_q[95:64];
    assign w2    = key_q[63:32];
    assign w3    = key_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    // round_q is the index of the key being replaced, so it selects Rcon of round_q+1
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t_w = sub_w ^ {rcon, 24'h000000};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (rk_ready) begin
                    if (round_q == 4'd10) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
`ifdef KEYEXP_ZEROIZE_EN
                        key_d   = 128'h0;
`endif
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                key_d   = {n0, n1, n2, n3};
                round_d = round_q + 4'd1;
                state_d = VALID;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = (state_q == VALID);
    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port key_in, input, 128 bits: cipher key, sampled only on an accepted key_load.
REQ-004 SHALL have port key_load, input, 1 bit: start request, one-cycle pulse.
REQ-005 SHALL have port rk_ready, input, 1 bit: downstream accepts rk_out.
REQ-006 SHALL have port rk_valid, output, 1 bit: rk_out holds a valid round key.
REQ-007 SHALL have port rk_out, output, 128 bits: current round key; w0 = [127:96], w3 = [31:0].
REQ-008 SHALL have port rk_round, output, 4 bits: index of rk_out, 0..10.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after round-10 key is accepted.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and VALID; rk_valid = (state == VALID).
REQ-012 IDLE: key_load=1 SHALL register key_in into the key register, set rk_round=0, go to VALID next cycle (1-cycle latency).
REQ-013 key_load SHALL be ignored in CALC and VALID; key register and rk_round unchanged.
REQ-014 VALID: rk_valid && rk_ready with rk_round<10 SHALL go to CALC; rk_ready=0 SHALL hold VALID with rk_out and rk_round stable.
REQ-015 CALC: SHALL register the next round key, increment rk_round, and go to VALID; CALC lasts exactly one cycle.
REQ-016 Next key SHALL be t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-017 RotWord(w3) SHALL be {w3[23:0], w3[31:24]}; SubWord SHALL use four instances of the team's sbox, one per byte.
REQ-018 Rcon for produced round r=1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-019 VALID: handshake with rk_round==10 SHALL go to IDLE and assert done for exactly that next cycle.
REQ-020 key_load SHALL be honoured in the IDLE cycle in which done is high.
REQ-021 Rounds SHALL be strictly sequential; no round skipped or repeated, rk_round never exceeds 10.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, rk_valid=0, done=0, busy=0, rk_round=0, rk_out=0, mid-sequence included.
REQ-023 After rst_n deasserts, the block SHALL stay IDLE until a fresh key_load; no partial sequence resumes.

Configuration
REQ-024 Macro KEYEXP_ZEROIZE_EN, when defined: the key register SHALL clear to 0 on the IDLE transition of REQ-019, so rk_out=0 in IDLE.
REQ-025 Without KEYEXP_ZEROIZE_EN: rk_out SHALL retain the round-10 key and rk_round SHALL retain 10 in IDLE until the next key_load or reset.

Verification
REQ-026 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round0 = key, round1 = a0fafe1788542cb123a339392a6c7605, round10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done pulses once.
REQ-027 Same key, rk_ready low 5 cycles at round 3 -> rk_out = 3d80477d4716fe3e1e237e446d7a883b held stable, rk_round=3, no advance.
REQ-028 key_load with key_in=0 issued while in VALID round 4 -> ignored; sequence completes with the original round keys.
REQ-029 rst_n pulsed low at round 6 -> outputs zero at once, IDLE; new key_load restarts at round 0 with correct keys.
REQ-030 Key all-zero completes; then IDLE -> rk_out = b4ef5bcb3e92e21123e951cf6f8f188e without KEYEXP_ZEROIZE_EN, all-zero with it.
REQ-031 key_load asserted in the done cycle -> accepted; round 0 of the new key is valid the next cycle.
